// File: rtl/pointer_frame_decoder.sv
// Host-side receiver for the CD-i pointing-device byte protocol: captures the device ID,
// reassembles 3-byte motion frames and integrates the deltas into a clamped cursor position.
module pointer_frame_decoder #(
    parameter int TIMEOUT_TICKS = 500000,
    parameter int POS_W         = 10,
    parameter int X_MAX         = 383,
    parameter int Y_MAX         = 279
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rts,
    input  logic [7:0]       serial_in_data,
    input  logic             serial_in_write,
    output logic [7:0]       device_id,
    output logic             id_valid,
    output logic             id_supported,
    output logic             frame_valid,
    output logic [1:0]       btn,
    output logic [7:0]       dx,
    output logic [7:0]       dy,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        ST_WAIT_ID = 2'd0,
        ST_HEAD    = 2'd1,
        ST_XLOW    = 2'd2,
        ST_YLOW    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   tmr_r;
    logic [5:0]         head_r;
    logic [5:0]         xlow_r;
    logic               in_frame_s;
    logic               timeout_s;
    logic               id_load_s;
    logic               head_load_s;
    logic               xlow_load_s;
    logic               frame_done_s;
    logic               err_s;
    logic [7:0]         dx_next_s;
    logic [7:0]         dy_next_s;

    logic [7:0]         device_id_r;
    logic               id_valid_r;
    logic               id_supported_r;
    logic               frame_valid_r;
    logic [1:0]         btn_r;
    logic [7:0]         dx_r;
    logic [7:0]         dy_r;
    logic [POS_W-1:0]   pos_x_r;
    logic [POS_W-1:0]   pos_y_r;
    logic               err_r;
    logic [7:0]         err_cnt_r;

    // Add a signed byte delta to a position with one guard bit, clamping into [0, max].
    function automatic logic [POS_W-1:0] clamp_add(
        input logic [POS_W-1:0] pos,
        input logic [7:0]       delta,
        input logic [POS_W-1:0] max
    );
        logic signed [POS_W:0] sum;
        sum = $signed({1'b0, pos}) + $signed({{(POS_W-7){delta[7]}}, delta});
        if (sum[POS_W]) begin
            return '0;
        end else if (sum > $signed({1'b0, max})) begin
            return max;
        end else begin
            return sum[POS_W-1:0];
        end
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic inc);
        if (inc && (value != 8'hFF)) begin
            return value + 8'd1;
        end else begin
            return value;
        end
    endfunction

    assign in_frame_s = (state_r == ST_XLOW) || (state_r == ST_YLOW);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_s  = in_frame_s && !rts && !serial_in_write &&
                        (tmr_r == CNT_W'(TIMEOUT_TICKS - 1));
    assign dx_next_s  = {head_r[1:0], xlow_r};
    assign dy_next_s  = {head_r[3:2], serial_in_data[5:0]};

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_WAIT_ID;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; rts overrides any byte in the same cycle.
    always_comb begin
        state_next_s = state_r;
        if (rts) begin
            state_next_s = ST_WAIT_ID;
        end else if (serial_in_write) begin
            case (state_r)
                ST_WAIT_ID: state_next_s = ST_HEAD;
                ST_HEAD: begin
                    if (serial_in_data[7:6] == 2'b11) begin
                        state_next_s = ST_XLOW;
                    end else begin
                        state_next_s = ST_HEAD;
                    end
                end
                ST_XLOW, ST_YLOW: begin
                    case (serial_in_data[7:6])
                        2'b10:   state_next_s = (state_r == ST_XLOW) ? ST_YLOW : ST_HEAD;
                        2'b11:   state_next_s = ST_XLOW;
                        default: state_next_s = ST_HEAD;
                    endcase
                end
                default: state_next_s = ST_WAIT_ID;
            endcase
        end else if (timeout_s) begin
            state_next_s = ST_HEAD;
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM control outputs: load strobes and error detection.
    always_comb begin
        id_load_s    = 1'b0;
        head_load_s  = 1'b0;
        xlow_load_s  = 1'b0;
        frame_done_s = 1'b0;
        err_s        = 1'b0;
        if (rts) begin
            err_s = 1'b0;
        end else if (serial_in_write) begin
            case (state_r)
                ST_WAIT_ID: id_load_s = 1'b1;
                ST_HEAD: begin
                    if (serial_in_data[7:6] == 2'b11) begin
                        head_load_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                ST_XLOW, ST_YLOW: begin
                    case (serial_in_data[7:6])
                        2'b10: begin
                            xlow_load_s  = (state_r == ST_XLOW);
                            frame_done_s = (state_r == ST_YLOW);
                        end
                        2'b11: begin
                            head_load_s = 1'b1;
                            err_s       = 1'b1;
                        end
                        default: err_s = 1'b1;
                    endcase
                end
                default: err_s = 1'b0;
            endcase
        end else begin
            err_s = timeout_s;
        end
    end

    // Inter-byte timer: runs only while a frame is partially received.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_r <= '0;
        end else if (rts || serial_in_write || !in_frame_s || timeout_s) begin
            tmr_r <= '0;
        end else begin
            tmr_r <= tmr_r + CNT_W'(1);
        end
    end

    // Device ID capture; rts only invalidates, the last ID value is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            device_id_r    <= 8'h00;
            id_valid_r     <= 1'b0;
            id_supported_r <= 1'b0;
        end else if (rts) begin
            id_valid_r <= 1'b0;
        end else if (id_load_s) begin
            device_id_r    <= serial_in_data;
            id_valid_r     <= 1'b1;
            id_supported_r <= (serial_in_data == 8'hCA) || (serial_in_data == 8'hCD);
        end
    end

    // Partial-frame holding registers (header payload and low X bits).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r <= 6'd0;
            xlow_r <= 6'd0;
        end else begin
            if (head_load_s) begin
                head_r <= serial_in_data[5:0];
            end
            if (xlow_load_s) begin
                xlow_r <= serial_in_data[5:0];
            end
        end
    end

    // Frame outputs and position integration on the final byte of a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid_r <= 1'b0;
            btn_r         <= 2'd0;
            dx_r          <= 8'd0;
            dy_r          <= 8'd0;
            pos_x_r       <= '0;
            pos_y_r       <= '0;
        end else begin
            frame_valid_r <= frame_done_s;
            if (frame_done_s) begin
                btn_r   <= {head_r[4], head_r[5]};
                dx_r    <= dx_next_s;
                dy_r    <= dy_next_s;
                pos_x_r <= clamp_add(pos_x_r, dx_next_s, POS_W'(X_MAX));
                pos_y_r <= clamp_add(pos_y_r, dy_next_s, POS_W'(Y_MAX));
            end
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            err_r     <= err_s;
            err_cnt_r <= sat_inc(err_cnt_r, err_s);
        end
    end

    assign device_id    = device_id_r;
    assign id_valid     = id_valid_r;
    assign id_supported = id_supported_r;
    assign frame_valid  = frame_valid_r;
    assign btn          = btn_r;
    assign dx           = dx_r;
    assign dy           = dy_r;
    assign pos_x        = pos_x_r;
    assign pos_y        = pos_y_r;
    assign err          = err_r;
    assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_pointer_frame_decoder.sv
// Bench for pointer_frame_decoder: a queue-based protocol model predicts every output each
// cycle; directed scenarios add literal expectations, then randomized traffic follows.
module tb_pointer_frame_decoder;

    localparam int T     = 64;
    localparam int POS_W = 10;
    localparam int X_MAX = 383;
    localparam int Y_MAX = 279;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             rts = 1'b0;
    logic [7:0]       serial_in_data = 8'h00;
    logic             serial_in_write = 1'b0;
    logic [7:0]       device_id;
    logic             id_valid;
    logic             id_supported;
    logic             frame_valid;
    logic [1:0]       btn;
    logic [7:0]       dx;
    logic [7:0]       dy;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             err;
    logic [7:0]       err_cnt;

    pointer_frame_decoder #(
        .TIMEOUT_TICKS(T), .POS_W(POS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rts(rts),
        .serial_in_data(serial_in_data), .serial_in_write(serial_in_write),
        .device_id(device_id), .id_valid(id_valid), .id_supported(id_supported),
        .frame_valid(frame_valid), .btn(btn), .dx(dx), .dy(dy),
        .pos_x(pos_x), .pos_y(pos_y), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int fv_seen = 0;
    int err_seen = 0;

    // Model state: expected outputs plus the bytes of the frame in progress.
    int e_dev, e_idv, e_sup, e_fv, e_btn, e_dx, e_dy, e_px, e_py, e_err, e_cnt;
    bit m_wait;
    logic [7:0] m_part[$];
    int m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_dev = 0; e_idv = 0; e_sup = 0; e_fv = 0; e_btn = 0; e_dx = 0; e_dy = 0;
        e_px = 0; e_py = 0; e_err = 0; e_cnt = 0;
        m_wait = 1'b1; m_part.delete(); m_idle = 0;
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // What the outputs must look like after one clock with these inputs.
    task automatic model_step(input bit r, input bit w, input logic [7:0] d);
        bit bad;
        int sx, sy;
        logic [7:0] h, xl, yl;
        bad = 1'b0;
        e_fv = 0;
        if (r) begin
            m_wait = 1'b1; m_part.delete(); m_idle = 0; e_idv = 0;
        end else if (w) begin
            m_idle = 0;
            if (m_wait) begin
                m_wait = 1'b0; e_dev = d; e_idv = 1;
                e_sup = (d == 8'hCA || d == 8'hCD) ? 1 : 0;
            end else if (m_part.size() == 0) begin
                if (d[7:6] == 2'b11) m_part.push_back(d);
                else bad = 1'b1;
            end else if (d[7:6] == 2'b10) begin
                m_part.push_back(d);
                if (m_part.size() == 3) begin
                    h = m_part[0]; xl = m_part[1]; yl = m_part[2];
                    sx = int'(h[1:0]) * 64 + int'(xl[5:0]);
                    sy = int'(h[3:2]) * 64 + int'(yl[5:0]);
                    if (sx > 127) sx -= 256;
                    if (sy > 127) sy -= 256;
                    e_fv = 1;
                    e_dx = sx & 255;
                    e_dy = sy & 255;
                    e_btn = int'(h[4]) * 2 + int'(h[5]);
                    e_px = clampi(e_px + sx, X_MAX);
                    e_py = clampi(e_py + sy, Y_MAX);
                    m_part.delete();
                end
            end else if (d[7:6] == 2'b11) begin
                bad = 1'b1; m_part.delete(); m_part.push_back(d);
            end else begin
                bad = 1'b1; m_part.delete();
            end
        end else if (m_part.size() > 0) begin
            m_idle++;
            if (m_idle == T) begin
                bad = 1'b1; m_part.delete(); m_idle = 0;
            end
        end
        e_err = bad ? 1 : 0;
        if (bad && e_cnt < 255) e_cnt++;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("device_id", device_id, e_dev);
            check("id_valid", id_valid, e_idv);
            check("id_supported", id_supported, e_sup);
            check("frame_valid", frame_valid, e_fv);
            check("btn", btn, e_btn);
            check("dx", dx, e_dx);
            check("dy", dy, e_dy);
            check("pos_x", pos_x, e_px);
            check("pos_y", pos_y, e_py);
            check("err", err, e_err);
            check("err_cnt", err_cnt, e_cnt);
            if (frame_valid) fv_seen++;
            if (err) err_seen++;
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [7:0] d);
        @(negedge clk);
        rts = r; serial_in_write = w; serial_in_data = d;
        model_step(r, w, d);
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; rts = 1'b0; serial_in_write = 1'b0; serial_in_data = 8'h00;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int act;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pos_x", pos_x, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_id_valid", id_valid, 0);
        reset_n = 1'b1;

        // Scenario 1: ID then one frame.
        cyc(1'b1, 1'b0, 8'h00);
        fv_seen = 0; err_seen = 0;
        send(8'hCD); send(8'hEC); send(8'h85); send(8'hBD);
        idle(2);
        check("s1_device_id", device_id, 8'hCD);
        check("s1_id_supported", id_supported, 1);
        check("s1_btn", btn, 2'b01);
        check("s1_dx", dx, 8'h05);
        check("s1_dy", dy, 8'hFD);
        check("s1_pos_x", pos_x, 5);
        check("s1_pos_y", pos_y, 0);
        check("s1_frames", fv_seen, 1);
        check("s1_errs", err_seen, 0);

        // Scenario 2: bit7=0 in YLOW aborts, then a good frame.
        cyc(1'b1, 1'b0, 8'h00);
        send(8'hCD); send(8'hEC); send(8'h85); send(8'h3D);
        send(8'hC0); send(8'h81); send(8'h81);
        idle(2);
        check("s2_dx", dx, 8'h01);
        check("s2_dy", dy, 8'h01);
        check("s2_btn", btn, 2'b00);
        check("s2_err_cnt", err_cnt, 1);
        check("s2_frames", fv_seen, 2);

        // Scenario 3: timeout fires exactly TIMEOUT_TICKS cycles after the last byte.
        do_reset();
        fv_seen = 0; err_seen = 0;
        cyc(1'b1, 1'b0, 8'h00);
        send(8'hCD); send(8'hF0);
        idle(T);
        check("s3_no_early_timeout", err_seen, 0);
        idle(1);
        check("s3_timeout_err", err_seen, 1);
        send(8'h85);
        idle(2);
        check("s3_err_cnt", err_cnt, 2);
        check("s3_frames", fv_seen, 0);

        // Scenario 4: byte on the expiry cycle is kept; clamping at both bounds.
        send(8'hC1); idle(T - 1); send(8'hBF); send(8'h82);
        send(8'hC1); send(8'hBF); send(8'h80);
        send(8'hC1); send(8'hBE); send(8'h80);
        idle(1);
        check("s4_pos_x_380", pos_x, 380);
        check("s4_pos_y_2", pos_y, 2);
        check("s4_err_cnt", err_cnt, 2);
        send(8'hC0); send(8'h8A); send(8'h80);
        idle(1);
        check("s4_clamp_x", pos_x, 383);
        send(8'hCC); send(8'h80); send(8'hB8);
        idle(1);
        check("s4_dy", dy, 8'hF8);
        check("s4_clamp_y", pos_y, 0);

        // Scenario 5: rts coincident with the last byte drops it.
        act = fv_seen;
        send(8'hEC); send(8'h85); cyc(1'b1, 1'b1, 8'hBD);
        idle(1);
        check("s5_id_valid_cleared", id_valid, 0);
        send(8'hCA);
        idle(1);
        check("s5_device_id", device_id, 8'hCA);
        check("s5_id_supported", id_supported, 1);
        check("s5_no_frame", fv_seen, act);

        // Randomized traffic.
        for (int it = 0; it < 500; it++) begin
            int sel;
            sel = $urandom_range(0, 99);
            b = 8'($urandom);
            if (sel < 3) begin
                cyc(1'b1, 1'($urandom_range(0, 1)), b);
                if ($urandom_range(0, 1) == 1) send(($urandom_range(0, 1) == 1) ? 8'hCA : 8'hCD);
            end else if (sel < 6) begin
                idle($urandom_range(T - 2, T + 2));
            end else if (sel < 20) begin
                idle(1);
            end else if (sel < 40) begin
                send(b);
            end else begin
                send(8'hC0 | (b & 8'h3F));
                if ($urandom_range(0, 3) == 0) idle(1);
                send(8'h80 | 8'($urandom_range(0, 63)));
                send(8'h80 | 8'($urandom_range(0, 63)));
            end
        end
        idle(2);

        // Scenario 6: error counter saturation, then asynchronous reset mid-frame.
        cyc(1'b1, 1'b0, 8'h00);
        send(8'hCD);
        for (int i = 0; i < 300; i++) send(8'h00);
        idle(1);
        check("s6_err_cnt_sat", err_cnt, 255);
        send(8'hC0); send(8'h81);
        @(negedge clk);
        serial_in_write = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("s6_rst_err_cnt", err_cnt, 0);
        check("s6_rst_pos_x", pos_x, 0);
        check("s6_rst_dx", dx, 0);
        check("s6_rst_device_id", device_id, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        chk_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
